// File: rtl/hwmod_log_pkg.sv
// Shared types and constants for the execution-proof log block.
// Cause queue depth and register map live here so the top and the FIFO agree.
package hwmod_log_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_LOST  = 2'd2
    } log_state_e;

    localparam logic [2:0] OFS_STATUS = 3'd0;
    localparam logic [2:0] OFS_VCNT   = 3'd1;
    localparam logic [2:0] OFS_CAUSE  = 3'd2;
    localparam logic [2:0] OFS_CTRL   = 3'd3;

    localparam int CTRL_CLR_VCNT = 0;
    localparam int CTRL_FLUSH    = 1;

    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/hwmod_log_fifo.sv
// Cause queue: FIFO_DEPTH entries of W bits, drop-on-full with sticky overflow.
// A pop in the same cycle frees the slot for a push on a full queue.
module hwmod_log_fifo
    import hwmod_log_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          do_push, do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CW'(FIFO_DEPTH));
    assign dout_o     = mem_q[rd_ptr_q];
    assign overflow_o = ovf_q;
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (push_i && !do_push) ovf_q <= 1'b1;
        end
    end

endmodule

// File: rtl/hwmod_exec_log.sv
// Execution-proof monitor log: tracks exec loss, queues loss causes, counts monitor resets.
// HWMOD_EXEC_LOG_FIFO_EN selects the 4-deep cause FIFO; otherwise a single cause register.
module hwmod_exec_log
    import hwmod_log_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0190,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        puc_n,
    input  logic        exec,
    input  logic        exec1,
    input  logic        exec2,
    input  logic        exec3,
    input  logic        exec4,
    input  logic        exec5,
    input  logic        mon_reset,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    output logic [15:0] per_dout
);
    log_state_e       state_q;
    logic             mon_q;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [15:0]      vcnt_ext;

    logic       sel, rd, ctrl_wr, clr_vcnt, flush, push, pop_req;
    logic [2:0] word;
    logic [4:0] cause_in, head;
    logic       fifo_empty, fifo_full, overflow;
    logic       unused_din;

    assign sel      = per_en && ({1'b0, per_addr[13:3]} == BASE_ADDR[15:4]);
    assign word     = per_addr[2:0];
    assign rd       = sel && (per_we == 2'b00);
    assign ctrl_wr  = sel && per_we[0] && (word == OFS_CTRL);
    assign clr_vcnt = ctrl_wr && per_din[CTRL_CLR_VCNT];
    assign flush    = ctrl_wr && per_din[CTRL_FLUSH];
    assign pop_req  = rd && (word == OFS_CAUSE);
    assign unused_din = ^per_din[15:2];

    // A cause bit is set for every sub-condition that failed when exec dropped.
    assign push     = (state_q == ST_VALID) && !exec;
    assign cause_in = ~{exec5, exec4, exec3, exec2, exec1};

    always_ff @(posedge clk or negedge puc_n) begin
        if (!puc_n) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (exec) state_q <= ST_VALID;
                ST_VALID: if (!exec) state_q <= ST_LOST;
                ST_LOST:  state_q <= exec ? ST_VALID : ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        vcnt_d = vcnt_q;
        if (clr_vcnt)
            vcnt_d = '0;
        else if (mon_reset && !mon_q && (vcnt_q != {CNT_W{1'b1}}))
            vcnt_d = vcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge puc_n) begin
        if (!puc_n) begin
            mon_q  <= 1'b0;
            vcnt_q <= '0;
        end else begin
            mon_q  <= mon_reset;
            vcnt_q <= vcnt_d;
        end
    end

    assign vcnt_ext = 16'(vcnt_q);

`ifdef HWMOD_EXEC_LOG_FIFO_EN
    hwmod_log_fifo #(.W(5)) u_fifo (
        .clk        (clk),
        .rst_n      (puc_n),
        .push_i     (push),
        .pop_i      (pop_req),
        .flush_i    (flush),
        .din_i      (cause_in),
        .dout_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (overflow)
    );
`else
    logic       valid_q, ovf_q;
    logic [4:0] cause_q;

    // A push landing on an unread cause overwrites it and flags the loss.
    always_ff @(posedge clk or negedge puc_n) begin
        if (!puc_n) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cause_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (push) begin
            cause_q <= cause_in;
            valid_q <= 1'b1;
            if (valid_q && !pop_req) ovf_q <= 1'b1;
        end else if (pop_req) begin
            valid_q <= 1'b0;
        end
    end

    assign head       = cause_q;
    assign fifo_empty = ~valid_q;
    assign fifo_full  = valid_q;
    assign overflow   = ovf_q;
`endif

    always_comb begin
        per_dout = 16'h0000;
        if (sel) begin
            case (word)
                OFS_STATUS: per_dout = {6'b0, (state_q == ST_LOST), overflow, fifo_full,
                                        fifo_empty, exec5, exec4, exec3, exec2, exec1, exec};
                OFS_VCNT:   per_dout = vcnt_ext;
                OFS_CAUSE:  per_dout = fifo_empty ? 16'h0000 : {11'b0, head};
                default:    per_dout = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_hwmod_exec_log.sv
// Directed bench for hwmod_exec_log; expectations adapt to HWMOD_EXEC_LOG_FIFO_EN.
module tb_hwmod_exec_log;

    logic        clk = 1'b0;
    logic        puc_n, exec, mon_reset, per_en;
    logic [4:0]  ex;
    logic [1:0]  per_we;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic [15:0] dout, dout8;
    logic [15:0] q, q8;
    int          total = 0;
    int          bad   = 0;

`ifdef HWMOD_EXEC_LOG_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif
    localparam logic [13:0] BASE_W = 14'h00C8;

    always #5 clk = ~clk;

    hwmod_exec_log dut (
        .clk(clk), .puc_n(puc_n), .exec(exec),
        .exec1(ex[0]), .exec2(ex[1]), .exec3(ex[2]), .exec4(ex[3]), .exec5(ex[4]),
        .mon_reset(mon_reset), .per_en(per_en), .per_we(per_we),
        .per_addr(per_addr), .per_din(per_din), .per_dout(dout)
    );

    hwmod_exec_log #(.CNT_W(8)) dut8 (
        .clk(clk), .puc_n(puc_n), .exec(exec),
        .exec1(ex[0]), .exec2(ex[1]), .exec3(ex[2]), .exec4(ex[3]), .exec5(ex[4]),
        .mon_reset(mon_reset), .per_en(per_en), .per_we(per_we),
        .per_addr(per_addr), .per_din(per_din), .per_dout(dout8)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Expected STATUS word; the single-register build reports full as ~empty.
    function automatic logic [15:0] st(input logic lost, input logic ovf, input logic full_f,
                                       input logic empty, input logic [4:0] e, input logic x);
        logic full;
        full = FIFO ? full_f : ~empty;
        return {6'b0, lost, ovf, full, empty, e, x};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic access(input logic [2:0] w, input logic [1:0] we, input logic [15:0] d);
        per_en = 1'b1; per_we = we; per_addr = BASE_W | {11'b0, w}; per_din = d;
        #1 q = dout; q8 = dout8;
        @(posedge clk);
        #2 per_en = 1'b0; per_we = 2'b00; per_din = 16'h0000;
    endtask

    task automatic rdchk(input logic [2:0] w, input string tag, input logic [15:0] exp);
        access(w, 2'b00, 16'h0000);
        chk(tag, q, exp);
    endtask

    task automatic drop(input logic [4:0] cause);
        exec = 1'b1; step(1);
        exec = 1'b0; ex = ~cause; step(1);
        ex = 5'h00; step(1);
    endtask

    task automatic pulse();
        mon_reset = 1'b1; step(1);
        mon_reset = 1'b0; step(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        puc_n = 1'b0; exec = 1'b0; ex = 5'h00; mon_reset = 1'b0;
        per_en = 1'b0; per_we = 2'b00; per_addr = 14'h0; per_din = 16'h0;
        #3 per_en = 1'b1; per_addr = BASE_W;
        #1 chk("rst_status_in_reset", dout, 16'h0040);
        per_en = 1'b0;
        @(posedge clk); #2 puc_n = 1'b1;
        step(1);

        rdchk(3'd0, "rst_status", 16'h0040);
        rdchk(3'd1, "rst_vcnt", 16'h0000);
        rdchk(3'd2, "rst_cause", 16'h0000);
        rdchk(3'd3, "ctrl_reads0", 16'h0000);
        per_addr = BASE_W; per_en = 1'b0;
        #1 chk("unselected", dout, 16'h0000);
        per_en = 1'b1; per_addr = 14'h00D0;
        #1 chk("wrong_addr", dout, 16'h0000);
        per_en = 1'b0; step(1);

        // Basic loss: exec high 3 cycles then drop with only exec1 failed.
        exec = 1'b1; step(3);
        exec = 1'b0; ex = 5'b11110;
        rdchk(3'd0, "live_status_valid", st(0, 0, 0, 1, 5'b11110, 0));
        rdchk(3'd0, "status_lost", st(1, 0, 0, 0, 5'b11110, 0));
        rdchk(3'd0, "status_lost_1cyc", st(0, 0, 0, 0, 5'b11110, 0));
        ex = 5'h00;
        rdchk(3'd2, "cause_exec1", 16'h0001);
        rdchk(3'd0, "status_empty_after", 16'h0040);
        rdchk(3'd2, "cause_empty", 16'h0000);

        // Live exec bits, then loss cause follows the inverted sub-flags.
        exec = 1'b1; ex = 5'h15;
        rdchk(3'd0, "live_exec_bits", 16'h006B);
        exec = 1'b0; step(1);
        ex = 5'h00; step(1);
        rdchk(3'd2, "cause_0a", 16'h000A);

        drop(5'h00);
        rdchk(3'd0, "zero_cause_pushed", st(0, 0, 0, 0, 5'h00, 0));
        rdchk(3'd2, "zero_cause_read", 16'h0000);
        rdchk(3'd0, "zero_cause_popped", 16'h0040);

        // Five drops without reading.
        for (int k = 1; k <= 5; k++) drop(5'(k));
        rdchk(3'd0, "full_ovf", st(0, 1, 1, 0, 5'h00, 0));
        if (FIFO) begin
            for (int k = 1; k <= 4; k++) rdchk(3'd2, "fifo_order", 16'(k));
        end else begin
            rdchk(3'd2, "single_last", 16'h0005);
        end
        rdchk(3'd2, "drained", 16'h0000);
        rdchk(3'd0, "ovf_sticky", st(0, 1, 0, 1, 5'h00, 0));
        access(3'd3, 2'b01, 16'h0002);
        rdchk(3'd0, "flush_clears_ovf", 16'h0040);

        // Push and flush together: flush wins.
        exec = 1'b1; step(1);
        exec = 1'b0; ex = ~5'h07;
        access(3'd3, 2'b01, 16'h0002);
        ex = 5'h00; step(1);
        rdchk(3'd0, "push_flush", 16'h0040);

        // Full queue, then pop and push on the same edge.
        for (int k = (FIFO ? 0 : 3); k <= 3; k++) drop(5'(8'h11 + k));
        exec = 1'b1; step(1);
        exec = 1'b0; ex = ~5'h15;
        rdchk(3'd2, "simul_pop", FIFO ? 16'h0011 : 16'h0014);
        ex = 5'h00; step(1);
        rdchk(3'd0, "simul_no_ovf", st(0, 0, 1, 0, 5'h00, 0));
        for (int k = (FIFO ? 1 : 4); k <= 4; k++) rdchk(3'd2, "simul_order", 16'(8'h11 + k));
        rdchk(3'd0, "simul_drained", 16'h0040);

        // VCNT edge counting and clear.
        for (int k = 0; k < 3; k++) begin
            mon_reset = 1'b1; step(1);
            mon_reset = 1'b0; step(2);
        end
        rdchk(3'd1, "vcnt3", 16'h0003);
        chk("vcnt3_w8", q8, 16'h0003);
        access(3'd7, 2'b11, 16'h0003);
        access(3'd5, 2'b11, 16'hFFFF);
        rdchk(3'd5, "word5_reads0", 16'h0000);
        rdchk(3'd1, "word7_write_ignored", 16'h0003);
        access(3'd3, 2'b10, 16'h0001);
        rdchk(3'd1, "ctrl_hi_byte_only", 16'h0003);
        mon_reset = 1'b1;
        access(3'd3, 2'b01, 16'h0001);
        mon_reset = 1'b0; step(1);
        rdchk(3'd1, "clr_beats_edge", 16'h0000);
        mon_reset = 1'b1; step(3);
        mon_reset = 1'b0; step(1);
        rdchk(3'd1, "level_counts_once", 16'h0001);

        // Saturation.
        access(3'd3, 2'b01, 16'h0001);
        for (int k = 0; k < 300; k++) pulse();
        rdchk(3'd1, "vcnt300_w16", 16'h012C);
        chk("vcnt_sat_w8", q8, 16'h00FF);

        // Reset mid-operation.
        access(3'd3, 2'b01, 16'h0003);
        for (int k = 0; k < 5; k++) pulse();
        drop(5'h0A);
        drop(5'h0B);
        rdchk(3'd1, "vcnt5", 16'h0005);
        rdchk(3'd0, "two_entries", st(0, !FIFO, 0, 0, 5'h00, 0));
        exec = 1'b1; ex = 5'h1F; mon_reset = 1'b1;
        puc_n = 1'b0;
        rdchk(3'd0, "reset_status_live", 16'h007F);
        exec = 1'b0; ex = 5'h00;
        rdchk(3'd0, "reset_status", 16'h0040);
        rdchk(3'd1, "reset_vcnt", 16'h0000);
        rdchk(3'd2, "reset_cause", 16'h0000);
        puc_n = 1'b1; step(1);
        mon_reset = 1'b0;
        rdchk(3'd2, "post_reset_cause", 16'h0000);
        rdchk(3'd0, "post_reset_status", 16'h0040);
        rdchk(3'd1, "mon_dly_cleared", 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hwmod_exec_log.md
HWMOD_EXEC_LOG -- requirements
Module: hwmod_exec_log

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0190, byte base address of the 4-word register window; 16-byte aligned.
REQ-002 Parameter CNT_W, default 16, width of the violation counter; range 8..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 puc_n  input  1  asynchronous, active-low reset.
REQ-005 exec  input  1  live execution-proof flag from the monitor.
REQ-006 exec1..exec5  input  1 each  monitor sub-condition flags, where 1 means the condition holds.
REQ-007 mon_reset  input  1  reset request from the monitor.
REQ-008 per_en  input  1  peripheral access strobe.
REQ-009 per_we  input  2  byte write enables; 2'b00 means read.
REQ-010 per_addr  input  14  word address, which is the byte address >> 1.
REQ-011 per_din  input  16  write data.
REQ-012 per_dout  output  16  read data; combinational and valid in the same cycle as per_en; 16'h0000 when the block is not selected.

Function
REQ-013 The block SHALL be selected when per_en=1 and per_addr[13:3]==BASE_ADDR[15:4]; per_addr[2:0] selects the word, and words 4..7 SHALL read 0 and ignore writes.
REQ-014 Word 0 STATUS (read-only) SHALL hold: bit0 exec, bits5:1 exec1..exec5 (live), bit6 fifo_empty, bit7 fifo_full, bit8 overflow, bit9 state==LOST, and 0 in bits 15:10.
REQ-015 Word 1 VCNT (read-only) SHALL be a zero-extended CNT_W counter of mon_reset rising edges that saturates at all-ones.
REQ-016 Word 2 CAUSE SHALL read {11'b0, cause[4:0]} from the FIFO head; a read with FIFO non-empty SHALL pop the head on that clock edge; a read with FIFO empty SHALL return 0 and not pop.
REQ-017 Word 3 CTRL (write-only, reads 0): a write with per_we[0]=1 and bit0=1 SHALL clear VCNT; bit1=1 SHALL flush the FIFO and clear overflow; both bits set SHALL do both in the same cycle.
REQ-018 FSM states are IDLE, VALID and LOST.
REQ-019 FSM transitions: IDLE->VALID on exec=1; VALID->LOST on exec=0; LOST->IDLE unconditionally after 1 cycle; LOST->VALID when exec=1 in the LOST cycle.
REQ-020 On the VALID->LOST edge the block SHALL push cause = ~{exec5,exec4,exec3,exec2,exec1}, sampled in the same cycle exec is seen low.
REQ-021 A cause of 5'b00000 SHALL still be pushed.
REQ-022 The FIFO SHALL be 4 entries deep; a push when full SHALL drop the new entry and set sticky overflow.
REQ-023 A simultaneous push and pop when full SHALL pop the head and accept the push, with no overflow.
REQ-024 A simultaneous push and flush SHALL flush and drop the push.
REQ-025 The VCNT edge detector SHALL use a registered copy of mon_reset; if a rising edge and a clear occur in the same cycle, the result SHALL be 0.
REQ-026 The FIFO pointers SHALL wrap modulo 4, with a separate occupancy count of 0..4.

Reset
REQ-027 While puc_n=0 the block SHALL hold: state=IDLE, FIFO empty, overflow=0, VCNT=0, mon_reset delay register=0.
REQ-028 per_dout SHALL follow REQ-012 during reset, reflecting the reset state.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents.

Configuration
REQ-030 With HWMOD_EXEC_LOG_FIFO_EN defined, the block SHALL behave as the 4-deep FIFO above.
REQ-031 With HWMOD_EXEC_LOG_FIFO_EN undefined, CAUSE SHALL be a single register that is overwritten on each push, with overflow set if it was still unread.
REQ-032 In the single-register build, a read SHALL mark the register empty; fifo_full SHALL equal ~fifo_empty.

Structure
REQ-033 A shared package hwmod_log_pkg SHALL hold the FSM state enum, the register word offsets (STATUS=0, VCNT=1, CAUSE=2, CTRL=3), the CTRL bit positions and FIFO_DEPTH=4.
REQ-034 One sub-module, hwmod_log_fifo (5-bit wide, depth from package, with push/pop/flush/full/empty/overflow), SHALL implement the cause queue.
REQ-035 hwmod_log_fifo SHALL be instantiated only under the macro; the single-register variant SHALL be inline.

Verification
REQ-036 Release reset, raise exec for 3 cycles, then drop exec with exec1=0 and exec2..5=1 -> STATUS bit9=1 for 1 cycle, CAUSE reads 16'h0001, and the next STATUS read shows bit6=1.
REQ-037 Drive 5 exec 1->0 drops without reading (FIFO build) -> fifo_full=1 and overflow=1; 4 CAUSE reads return entries in order, then the 5th read returns 0.
REQ-038 Pulse mon_reset 3 times with 2-cycle gaps -> VCNT=3; write CTRL=16'h0001 in the same cycle as a 4th rising edge -> VCNT=0.
REQ-039 With CNT_W=8, drive 300 mon_reset edges -> VCNT=16'h00FF.
REQ-040 Fill the FIFO, then in one cycle read CAUSE while an exec drop occurs -> occupancy stays 4 and overflow=0.
REQ-041 Assert puc_n=0 with 2 FIFO entries and VCNT=5 -> all registers read 0 and STATUS=16'h0040 once exec and exec1..5 are 0.
